// File: rtl/wallace_mul32_seq_if.sv
// Operand/product handshake bundle for wallace_mul32_seq.
// The signed_op lane exists only when WALLACE_MUL32_SIGNED_EN is defined.
interface wallace_mul32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
`ifdef WALLACE_MUL32_SIGNED_EN
  logic        signed_op;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;
  logic        busy;

  modport master (
`ifdef WALLACE_MUL32_SIGNED_EN
    output signed_op,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
`ifdef WALLACE_MUL32_SIGNED_EN
    input  signed_op,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/wallace_mul32_seq.sv
// Iterative 32x32 multiplier: one 16x16 Wallace tree reused over four cycles.
// Define WALLACE_MUL32_SIGNED_EN to add two's-complement operands via signed_op.
module wallacetree16x16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  logic [31:0] r0 [16];
  logic [31:0] r1 [11];
  logic [31:0] r2 [8];
  logic [31:0] r3 [6];
  logic [31:0] r4 [4];
  logic [31:0] r5 [3];
  logic [31:0] r6 [2];

  function automatic logic [63:0] csa(input logic [31:0] u, input logic [31:0] v,
                                      input logic [31:0] w);
    logic [31:0] maj;
    maj = (u & v) | (u & w) | (v & w);
    return {maj[30:0], 1'b0, u ^ v ^ w};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign r0[i] = {16'b0, x & {16{y[i]}}} << i;
  end

  // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add
  always_comb begin
    {r1[1], r1[0]} = csa(r0[0],  r0[1],  r0[2]);
    {r1[3], r1[2]} = csa(r0[3],  r0[4],  r0[5]);
    {r1[5], r1[4]} = csa(r0[6],  r0[7],  r0[8]);
    {r1[7], r1[6]} = csa(r0[9],  r0[10], r0[11]);
    {r1[9], r1[8]} = csa(r0[12], r0[13], r0[14]);
    r1[10] = r0[15];
    {r2[1], r2[0]} = csa(r1[0], r1[1], r1[2]);
    {r2[3], r2[2]} = csa(r1[3], r1[4], r1[5]);
    {r2[5], r2[4]} = csa(r1[6], r1[7], r1[8]);
    r2[6] = r1[9];
    r2[7] = r1[10];
    {r3[1], r3[0]} = csa(r2[0], r2[1], r2[2]);
    {r3[3], r3[2]} = csa(r2[3], r2[4], r2[5]);
    r3[4] = r2[6];
    r3[5] = r2[7];
    {r4[1], r4[0]} = csa(r3[0], r3[1], r3[2]);
    {r4[3], r4[2]} = csa(r3[3], r3[4], r3[5]);
    {r5[1], r5[0]} = csa(r4[0], r4[1], r4[2]);
    r5[2] = r4[3];
    {r6[1], r6[0]} = csa(r5[0], r5[1], r5[2]);
    p = r6[0] + r6[1];
  end
endmodule

module wallace_mul32_seq (
  input  logic                clk,
  input  logic                rst,
  wallace_mul32_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [15:0] core_x, core_y;
  logic [31:0] core_p;
  logic [63:0] addend, sum;
`ifdef WALLACE_MUL32_SIGNED_EN
  logic        neg_q, neg_d;

  // 0x80000000 negates to itself, which is already the correct unsigned magnitude
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction
`endif

  always_comb begin
    unique case (step_q)
      2'd0:    begin core_x = a_q[15:0];  core_y = b_q[15:0];  end
      2'd1:    begin core_x = a_q[15:0];  core_y = b_q[31:16]; end
      2'd2:    begin core_x = a_q[31:16]; core_y = b_q[15:0];  end
      default: begin core_x = a_q[31:16]; core_y = b_q[31:16]; end
    endcase
  end

  wallacetree16x16 u_core (.x(core_x), .y(core_y), .p(core_p));

  always_comb begin
    unique case (step_q)
      2'd0:    addend = {32'b0, core_p};
      2'd1,
      2'd2:    addend = {16'b0, core_p, 16'b0};
      default: addend = {core_p, 32'b0};
    endcase
    sum = acc_q + addend;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef WALLACE_MUL32_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef WALLACE_MUL32_SIGNED_EN
          if (bus.signed_op) begin
            a_d   = mag32(bus.a);
            b_d   = mag32(bus.b);
            neg_d = bus.a[31] ^ bus.b[31];
          end else begin
            a_d   = bus.a;
            b_d   = bus.b;
            neg_d = 1'b0;
          end
`else
          a_d = bus.a;
          b_d = bus.b;
`endif
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d  = sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_DONE;
`ifdef WALLACE_MUL32_SIGNED_EN
          if (neg_q) acc_d = -sum;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef WALLACE_MUL32_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef WALLACE_MUL32_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.prod      = acc_q;
endmodule

// File: tb/tb_wallace_mul32_seq.sv
// Directed-vector bench for wallace_mul32_seq (signed vectors run when
// WALLACE_MUL32_SIGNED_EN is defined).
module tb_wallace_mul32_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wallace_mul32_seq_if bus();

  wallace_mul32_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic sop);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("accept_ready", {63'b0, bus.in_ready}, 64'd1);
    bus.a        = av;
    bus.b        = bv;
`ifdef WALLACE_MUL32_SIGNED_EN
    bus.signed_op = sop;
`else
    if (sop) $display("note: signed vector skipped in unsigned build");
`endif
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    if (!bus.out_valid) check_eq("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("consume_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("consume_in_ready", {63'b0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sop, input logic [63:0] exp);
    int cyc;
    accept(av, bv, sop);
    wait_valid(cyc);
    check_eq({tag, "_prod"}, bus.prod, exp);
    check_eq({tag, "_latency"}, 64'(cyc), 64'd4);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
`ifdef WALLACE_MUL32_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("rst_busy", {63'b0, bus.busy}, 64'd0);
    check_eq("rst_prod", bus.prod, 64'd0);
    check_eq("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

    run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);

    // Backpressure: result and handshake must hold for 10 cycles
    accept(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    check_eq("mul_busy", {63'b0, bus.busy}, 64'd1);
    check_eq("mul_in_ready", {63'b0, bus.in_ready}, 64'd0);
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_out_valid", {63'b0, bus.out_valid}, 64'd1);
      check_eq("bp_prod", bus.prod, 64'h0B00_EA4E_242D_2080);
      check_eq("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
      tick();
    end
    consume();

    // in_valid during MUL must be ignored
    accept(32'hDEAD_BEEF, 32'h0000_0002, 1'b0);
    tick();
    bus.a = 32'd5;
    bus.b = 32'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    check_eq("ignore_prod", bus.prod, 64'h0000_0001_BD5B_7DDE);
    consume();
    run_op("five_seven", 32'd5, 32'd7, 1'b0, 64'h23);

    // Reset asserted during the step2 cycle aborts the operation
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("abort_busy", {63'b0, bus.busy}, 64'd0);
    check_eq("abort_prod", bus.prod, 64'd0);
    check_eq("abort_in_ready", {63'b0, bus.in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("abort_no_result", {63'b0, bus.out_valid}, 64'd0);
      tick();
    end

    // Back-to-back with out_ready held high and in_valid kept asserted
    bus.out_ready = 1'b1;
    accept(32'd3, 32'd4, 1'b0);
    bus.a = 32'd0;
    bus.b = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    wait_valid(cyc);
    check_eq("b2b_first_prod", bus.prod, 64'hC);
    check_eq("b2b_first_latency", 64'(cyc), 64'd4);
    check_eq("b2b_no_accept_in_done", {63'b0, bus.in_ready}, 64'd0);
    tick();
    check_eq("b2b_idle_gap", {63'b0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("b2b_second_busy", {63'b0, bus.busy}, 64'd1);
    wait_valid(cyc);
    check_eq("b2b_second_prod", bus.prod, 64'h0);
    check_eq("b2b_second_latency", 64'(cyc), 64'd4);
    tick();
    bus.out_ready = 1'b0;
    check_eq("b2b_done", {63'b0, bus.out_valid}, 64'd0);

`ifdef WALLACE_MUL32_SIGNED_EN
    run_op("s_m1x3", 32'hFFFF_FFFF, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op("s_min_x1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op("u_m1x3", 32'hFFFF_FFFF, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFFD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
